// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - requester handshake and register-file write port bundle
// master = requester/write-port observer side, slave = arbiter side.
interface rf_write_arbiter_if #(
   parameter int W = 8,
   parameter int D = 3
);
   logic         start;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [D-1:0] req_addr0;
   logic [D-1:0] req_addr1;
   logic         req_pair0;
   logic         req_pair1;
   logic [W-1:0] req_dataA0;
   logic [W-1:0] req_dataA1;
   logic [W-1:0] req_dataB0;
   logic [W-1:0] req_dataB1;
   logic         wr_en;
   logic [D-1:0] wr_addr;
   logic [W-1:0] wr_data;
   logic         busy;
   logic         grant_id;

   modport master (
      output start, req_valid, req_addr0, req_addr1, req_pair0, req_pair1,
             req_dataA0, req_dataA1, req_dataB0, req_dataB1,
      input  req_ready, wr_en, wr_addr, wr_data, busy, grant_id
   );

   modport slave (
      input  start, req_valid, req_addr0, req_addr1, req_pair0, req_pair1,
             req_dataA0, req_dataA1, req_dataB0, req_dataB1,
      output req_ready, wr_en, wr_addr, wr_data, busy, grant_id
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter sharing one register-file write port
// Pair writes (addr, addr+1) are built only when RF_ARB_PAIR_EN is defined.
module rf_write_arbiter #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic              CLK,
   input  logic              Reset,
   rf_write_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2
   } state_t;

   state_t       state_q;
   logic         grant_id_q;
   logic         prio_q;
   logic         wr_en_q;
   logic [D-1:0] wr_addr_q;
   logic [W-1:0] wr_data_q;

   logic         can_accept;
   logic         accept;
   logic         sel;
   logic [D-1:0] sel_addr;
   logic [W-1:0] sel_dataa;

`ifdef RF_ARB_PAIR_EN
   logic [D-1:0] addr_q;
   logic         pair_q;
   logic [W-1:0] datab_q;
   logic         sel_pair;
   logic [W-1:0] sel_datab;
   logic [D-1:0] hi_addr;

   assign hi_addr = addr_q + D'(1);
`else
   logic         unused_pair;

   assign unused_pair = ^{bus.req_pair0, bus.req_pair1, bus.req_dataB0, bus.req_dataB1};
`endif

   always_comb begin
`ifdef RF_ARB_PAIR_EN
      can_accept = (state_q == S_IDLE) || (state_q == S_HI) || ((state_q == S_LO) && !pair_q);
      sel_pair   = 1'b0;
      sel_datab  = '0;
`else
      can_accept = (state_q == S_IDLE) || (state_q == S_LO);
`endif
      // With a lone requester valid its own bit picks it; with both, the pointer decides.
      sel       = (&bus.req_valid) ? prio_q : bus.req_valid[1];
      accept    = can_accept && !bus.start && !Reset && (|bus.req_valid);
      sel_addr  = sel ? bus.req_addr1  : bus.req_addr0;
      sel_dataa = sel ? bus.req_dataA1 : bus.req_dataA0;
`ifdef RF_ARB_PAIR_EN
      sel_pair  = sel ? bus.req_pair1  : bus.req_pair0;
      sel_datab = sel ? bus.req_dataB1 : bus.req_dataB0;
`endif
   end

   assign bus.req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         grant_id_q <= 1'b0;
         prio_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
`ifdef RF_ARB_PAIR_EN
         addr_q     <= '0;
         pair_q     <= 1'b0;
         datab_q    <= '0;
`endif
      end else if (bus.start) begin
         state_q <= S_IDLE;
         wr_en_q <= 1'b0;
         prio_q  <= 1'b0;
      end else if (accept) begin
         state_q    <= S_LO;
         wr_en_q    <= (sel_addr != '0);
         wr_addr_q  <= sel_addr;
         wr_data_q  <= sel_dataa;
         grant_id_q <= sel;
         prio_q     <= ~sel;
`ifdef RF_ARB_PAIR_EN
         addr_q     <= sel_addr;
         pair_q     <= sel_pair;
         datab_q    <= sel_datab;
`endif
      end else begin
`ifdef RF_ARB_PAIR_EN
         if ((state_q == S_LO) && pair_q) begin
            state_q   <= S_HI;
            wr_en_q   <= (hi_addr != '0);
            wr_addr_q <= hi_addr;
            wr_data_q <= datab_q;
         end else begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
         end
`else
         state_q <= S_IDLE;
         wr_en_q <= 1'b0;
`endif
      end
   end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter (RF_ARB_PAIR_EN aware)
module tb_rf_write_arbiter;
   localparam int W = 8;
   localparam int D = 3;
`ifdef RF_ARB_PAIR_EN
   localparam bit PAIR_EN = 1'b1;
`else
   localparam bit PAIR_EN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic Reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   rf_write_arbiter_if #(.W(W), .D(D)) bus ();
   rf_write_arbiter #(.W(W), .D(D)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of beats still owed after the one on the write port.
   typedef struct {
      logic [D-1:0] addr;
      logic [W-1:0] data;
      logic         owner;
   } beat_t;

   beat_t        pend[$];
   bit           cur_v;
   logic [D-1:0] m_addr;
   logic [W-1:0] m_data;
   logic         m_owner;
   logic         m_prio;
   logic [1:0]   m_ready;
   bit           m_hs;
   logic         m_id;

   function automatic void model_reset();
      pend.delete();
      cur_v   = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_owner = 1'b0;
      m_prio  = 1'b0;
   endfunction

   function automatic void present(input beat_t b);
      cur_v   = 1'b1;
      m_addr  = b.addr;
      m_data  = b.data;
      m_owner = b.owner;
   endfunction

   function automatic void take(input logic id);
      beat_t        lo;
      beat_t        hi;
      logic [D-1:0] nx;
      lo.addr  = id ? bus.req_addr1 : bus.req_addr0;
      lo.data  = id ? bus.req_dataA1 : bus.req_dataA0;
      lo.owner = id;
      if (PAIR_EN && (id ? bus.req_pair1 : bus.req_pair0)) begin
         nx       = lo.addr + D'(1);
         hi.addr  = nx;
         hi.data  = id ? bus.req_dataB1 : bus.req_dataB0;
         hi.owner = id;
         pend.push_back(hi);
      end
      present(lo);
      m_prio = ~id;
   endfunction

   initial begin
      beat_t b;
      model_reset();
      forever begin
         @(negedge CLK);
         if (Reset) model_reset();
         m_ready = 2'b00;
         m_hs    = 1'b0;
         if (!Reset && !bus.start && pend.size() == 0 && bus.req_valid != 2'b00) begin
            m_id = (bus.req_valid == 2'b11) ? m_prio : bus.req_valid[1];
            m_ready[m_id] = 1'b1;
            m_hs = 1'b1;
         end
         chk("model_req_ready", 32'(bus.req_ready), 32'(m_ready));
         chk("model_wr_en",     32'(bus.wr_en),     32'(cur_v && (m_addr != '0)));
         chk("model_wr_addr",   32'(bus.wr_addr),   32'(m_addr));
         chk("model_wr_data",   32'(bus.wr_data),   32'(m_data));
         chk("model_busy",      32'(bus.busy),      32'(cur_v));
         chk("model_grant_id",  32'(bus.grant_id),  32'(m_owner));
         @(posedge CLK);
         if (Reset) model_reset();
         else if (bus.start) begin
            pend.delete();
            cur_v  = 1'b0;
            m_prio = 1'b0;
         end else if (m_hs) take(m_id);
         else if (pend.size() > 0) begin
            b = pend.pop_front();
            present(b);
         end else cur_v = 1'b0;
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set0(input logic [D-1:0] a, input logic p, input logic [W-1:0] da, input logic [W-1:0] db);
      bus.req_addr0 = a; bus.req_pair0 = p; bus.req_dataA0 = da; bus.req_dataB0 = db;
   endtask

   task automatic set1(input logic [D-1:0] a, input logic p, input logic [W-1:0] da, input logic [W-1:0] db);
      bus.req_addr1 = a; bus.req_pair1 = p; bus.req_dataA1 = da; bus.req_dataB1 = db;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.req_valid = 2'b11;
      set0(3'd0, 1'b0, 8'h00, 8'h00);
      set1(3'd0, 1'b0, 8'h00, 8'h00);
      @(negedge CLK);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_wr_en",     32'(bus.wr_en),     32'h0);
      chk("rst_wr_addr",   32'(bus.wr_addr),   32'h0);
      chk("rst_wr_data",   32'(bus.wr_data),   32'h0);
      chk("rst_busy",      32'(bus.busy),      32'h0);
      chk("rst_grant_id",  32'(bus.grant_id),  32'h0);
      cyc(); Reset = 1'b0; bus.req_valid = 2'b00;
      cyc();

      // single write from requester 0
      set0(3'd3, 1'b0, 8'h5A, 8'h00); bus.req_valid = 2'b01;
      @(negedge CLK); chk("single_ready", 32'(bus.req_ready), 32'h1);
      cyc(); bus.req_valid = 2'b00;
      @(negedge CLK);
      chk("single_wr_en",   32'(bus.wr_en),   32'h1);
      chk("single_wr_addr", 32'(bus.wr_addr), 32'h3);
      chk("single_wr_data", 32'(bus.wr_data), 32'h5A);
      cyc();
      @(negedge CLK); chk("single_idle_busy", 32'(bus.busy), 32'h0);
      cyc();

      // pair from requester 1, requester 0 waiting behind it
      set1(3'd4, 1'b1, 8'h11, 8'h22); bus.req_valid = 2'b10;
      @(negedge CLK); chk("pair_ready", 32'(bus.req_ready), 32'h2);
      cyc(); set0(3'd6, 1'b0, 8'h66, 8'h00); bus.req_valid = 2'b01;
      @(negedge CLK);
      chk("pair_lo_addr",  32'(bus.wr_addr),  32'h4);
      chk("pair_lo_data",  32'(bus.wr_data),  32'h11);
      chk("pair_lo_grant", 32'(bus.grant_id), 32'h1);
`ifdef RF_ARB_PAIR_EN
      chk("pair_lo_blocks", 32'(bus.req_ready), 32'h0);
      cyc();
      @(negedge CLK);
      chk("pair_hi_addr",  32'(bus.wr_addr),   32'h5);
      chk("pair_hi_data",  32'(bus.wr_data),   32'h22);
      chk("pair_hi_ready", 32'(bus.req_ready), 32'h1);
      cyc(); bus.req_valid = 2'b00;
`else
      chk("nopair_b2b_ready", 32'(bus.req_ready), 32'h1);
      cyc(); bus.req_valid = 2'b00;
`endif
      @(negedge CLK);
      chk("follow_addr", 32'(bus.wr_addr), 32'h6);
      chk("follow_data", 32'(bus.wr_data), 32'h66);
      cyc(); cyc();

      // start beats simultaneous valid, then round-robin from prio 0
      set0(3'd1, 1'b0, 8'hA1, 8'h00); set1(3'd2, 1'b0, 8'hB2, 8'h00);
      bus.start = 1'b1; bus.req_valid = 2'b11;
      @(negedge CLK); chk("start_blocks_ready", 32'(bus.req_ready), 32'h0);
      cyc(); bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("rr_ready", 32'(bus.req_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
         if (i > 0) chk("rr_wr_addr", 32'(bus.wr_addr), (i % 2 == 1) ? 32'h1 : 32'h2);
         cyc();
      end
      bus.req_valid = 2'b00;
      cyc(); cyc();

      // pair wrapping from 7 to register 0
      set0(3'd7, 1'b1, 8'hAA, 8'hBB); bus.req_valid = 2'b01;
      cyc(); bus.req_valid = 2'b00;
      @(negedge CLK);
      chk("wrap_lo_en",   32'(bus.wr_en),   32'h1);
      chk("wrap_lo_addr", 32'(bus.wr_addr), 32'h7);
      chk("wrap_lo_data", 32'(bus.wr_data), 32'hAA);
`ifdef RF_ARB_PAIR_EN
      cyc();
      @(negedge CLK);
      chk("wrap_hi_en",   32'(bus.wr_en),   32'h0);
      chk("wrap_hi_addr", 32'(bus.wr_addr), 32'h0);
      chk("wrap_hi_data", 32'(bus.wr_data), 32'hBB);
      chk("wrap_hi_busy", 32'(bus.busy),    32'h1);
`endif
      cyc(); cyc();

      // single to register 0 is suppressed
      set1(3'd0, 1'b0, 8'h3C, 8'h00); bus.req_valid = 2'b10;
      cyc(); bus.req_valid = 2'b00;
      @(negedge CLK);
      chk("zero_en",   32'(bus.wr_en),   32'h0);
      chk("zero_data", 32'(bus.wr_data), 32'h3C);
      chk("zero_busy", 32'(bus.busy),    32'h1);
      cyc(); cyc();

      // start aborts a pair after its LO beat and clears the pointer
      set0(3'd4, 1'b1, 8'hC4, 8'hD5); bus.req_valid = 2'b01;
      cyc(); bus.req_valid = 2'b00; bus.start = 1'b1;
      @(negedge CLK);
      chk("abort_lo_en",   32'(bus.wr_en),   32'h1);
      chk("abort_lo_addr", 32'(bus.wr_addr), 32'h4);
      cyc(); bus.start = 1'b0;
      set0(3'd5, 1'b0, 8'h55, 8'h00); set1(3'd6, 1'b0, 8'h66, 8'h00); bus.req_valid = 2'b11;
      @(negedge CLK);
      chk("abort_no_hi_en", 32'(bus.wr_en),     32'h0);
      chk("abort_busy",     32'(bus.busy),      32'h0);
      chk("abort_prio0",    32'(bus.req_ready), 32'h1);
      cyc(); bus.req_valid = 2'b00;
      cyc(); cyc();

      // asynchronous reset during the LO beat of a pair
      set1(3'd3, 1'b1, 8'hE1, 8'hE2); bus.req_valid = 2'b10;
      cyc(); bus.req_valid = 2'b00;
      @(negedge CLK); chk("rstmid_lo_addr", 32'(bus.wr_addr), 32'h3);
      #1 Reset = 1'b1;
      #1;
      chk("rstmid_wr_en",    32'(bus.wr_en),    32'h0);
      chk("rstmid_wr_addr",  32'(bus.wr_addr),  32'h0);
      chk("rstmid_wr_data",  32'(bus.wr_data),  32'h0);
      chk("rstmid_busy",     32'(bus.busy),     32'h0);
      chk("rstmid_grant_id", 32'(bus.grant_id), 32'h0);
      cyc(); Reset = 1'b0;
      @(negedge CLK);
      chk("rstmid_no_hi_en", 32'(bus.wr_en), 32'h0);
      chk("rstmid_no_hi_busy", 32'(bus.busy), 32'h0);
      cyc(); cyc(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
